dispatch_multi_fu: RTL and testbench

//  Parametrised dispatch stage between rename and N_FU reservation stations.
//  - Buffers each renamed uop in a per-FU FIFO; grants one uop/cycle round-robin.
//  - Allocates the ROB entry and resolves source readiness (PRF query + CDB bypass).
//  - On mispredict, squashes only the uops younger than the flushing branch.

---
 rtl/dispatch_multi_fu.sv | 192 +++++++++++++++++++
 tb/tb_dispatch_multi_fu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_multi_fu.sv
// rtl/dispatch_multi_fu.sv - per-FU dispatch FIFOs with round-robin grant, ROB alloc and partial flush
module dispatch_multi_fu #(
   parameter int N_FU      = 3,
   parameter int DEPTH     = 2,
   parameter int PREG_W    = 7,
   parameter int ROB_W     = 5,
   parameter int N_CDB     = 3,
   parameter int PAYLOAD_W = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [N_FU-1:0]                    in_fu_sel,
   input  logic [PREG_W-1:0]                  in_pd_new,
   input  logic [PREG_W-1:0]                  in_pd_old,
   input  logic [PREG_W-1:0]                  in_ps1,
   input  logic [PREG_W-1:0]                  in_ps2,
   input  logic [ROB_W-1:0]                   in_rob_tag,
   input  logic [PAYLOAD_W-1:0]               in_payload,
   output logic                               nr_valid,
   output logic [PREG_W-1:0]                  nr_reg,
   output logic [PREG_W-1:0]                  query_ps1,
   output logic [PREG_W-1:0]                  query_ps2,
   input  logic                               prf_rdy1,
   input  logic                               prf_rdy2,
   input  logic [N_CDB-1:0]                   cdb_valid,
   input  logic [N_CDB*PREG_W-1:0]            cdb_preg,
   input  logic [N_FU-1:0]                    rs_ready,
   output logic [N_FU-1:0]                    rs_valid,
   output logic [PREG_W-1:0]                  out_pd_new,
   output logic [PREG_W-1:0]                  out_ps1,
   output logic [PREG_W-1:0]                  out_ps2,
   output logic [ROB_W-1:0]                   out_rob_tag,
   output logic [PAYLOAD_W-1:0]               out_payload,
   output logic                               out_rdy1,
   output logic                               out_rdy2,
   input  logic                               rob_full,
   input  logic [ROB_W-1:0]                   rob_head,
   output logic                               rob_we,
   output logic [PREG_W-1:0]                  rob_pd_new,
   output logic [PREG_W-1:0]                  rob_pd_old,
   input  logic                               flush,
   input  logic [ROB_W-1:0]                   flush_tag,
   output logic [N_FU*($clog2(DEPTH)+1)-1:0]  fifo_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SEL_W = $clog2(N_FU);

   typedef struct packed {
      logic [PREG_W-1:0]    pd_new;
      logic [PREG_W-1:0]    pd_old;
      logic [PREG_W-1:0]    ps1;
      logic [PREG_W-1:0]    ps2;
      logic [ROB_W-1:0]     tag;
      logic [PAYLOAD_W-1:0] payload;
   } uop_t;

   uop_t             mem [N_FU][DEPTH];
   uop_t             in_uop;
   uop_t             head_uop;
   logic [PTR_W-1:0] head [N_FU];
   logic [CNT_W-1:0] cnt  [N_FU];
   logic [CNT_W-1:0] keep [N_FU];
   logic [SEL_W-1:0] rr, sel, gnt;
   logic             gnt_any, accept;
   logic [N_FU-1:0]  elig, push_fu, pop_fu;
   logic [2*N_FU-1:0] elig2;

   function automatic logic src_rdy(input logic [PREG_W-1:0] ps, input logic prf,
                                    input logic [N_CDB-1:0] cv, input logic [N_CDB*PREG_W-1:0] cp);
      src_rdy = (ps == '0) || prf;
      for (int k = 0; k < N_CDB; k++)
         if (cv[k] && cp[k*PREG_W +: PREG_W] == ps) src_rdy = 1'b1;
   endfunction

   assign in_uop = '{pd_new: in_pd_new, pd_old: in_pd_old, ps1: in_ps1, ps2: in_ps2,
                     tag: in_rob_tag, payload: in_payload};

   always_comb begin
      sel = '0;
      for (int i = N_FU-1; i >= 0; i--)
         if (in_fu_sel[i]) sel = SEL_W'(i);
   end

   // an empty fu_sel is accepted and dropped so rename never stalls on it
   assign in_ready = !flush && ((in_fu_sel == '0) || (cnt[sel] < CNT_W'(DEPTH)));
   assign accept   = in_valid && in_ready && (in_fu_sel != '0);
   assign nr_valid = accept && (in_pd_new != '0);
   assign nr_reg   = in_pd_new;

   always_comb begin
      for (int i = 0; i < N_FU; i++)
         elig[i] = (cnt[i] != '0) && rs_ready[i] && !rob_full && !flush;
   end
   assign elig2 = {elig, elig};

   always_comb begin
      gnt_any = 1'b0;
      gnt     = '0;
      for (int k = 0; k < N_FU; k++) begin
         if (!gnt_any && elig2[int'(rr) + k]) begin
            gnt_any = 1'b1;
            gnt     = (int'(rr) + k >= N_FU) ? SEL_W'(int'(rr) + k - N_FU) : SEL_W'(int'(rr) + k);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_FU; i++) begin
         push_fu[i] = accept && (sel == SEL_W'(i));
         pop_fu[i]  = gnt_any && (gnt == SEL_W'(i));
      end
   end

   // survivors form a head prefix, so counting them gives the retracted tail directly
   always_comb begin
      for (int i = 0; i < N_FU; i++) begin
         keep[i] = '0;
         for (int j = 0; j < DEPTH; j++)
            if ((CNT_W'(j) < cnt[i]) &&
                (ROB_W'(mem[i][head[i] + PTR_W'(j)].tag - rob_head) <= ROB_W'(flush_tag - rob_head)))
               keep[i] = keep[i] + CNT_W'(1);
      end
   end

   assign head_uop = mem[gnt][head[gnt]];

   always_comb begin
      rs_valid    = '0;
      rob_we      = 1'b0;
      out_pd_new  = '0;
      out_ps1     = '0;
      out_ps2     = '0;
      out_rob_tag = '0;
      out_payload = '0;
      out_rdy1    = 1'b0;
      out_rdy2    = 1'b0;
      rob_pd_new  = '0;
      rob_pd_old  = '0;
      query_ps1   = '0;
      query_ps2   = '0;
      if (gnt_any) begin
         rs_valid[gnt] = 1'b1;
         rob_we        = 1'b1;
         out_pd_new    = head_uop.pd_new;
         out_ps1       = head_uop.ps1;
         out_ps2       = head_uop.ps2;
         out_rob_tag   = head_uop.tag;
         out_payload   = head_uop.payload;
         out_rdy1      = src_rdy(head_uop.ps1, prf_rdy1, cdb_valid, cdb_preg);
         out_rdy2      = src_rdy(head_uop.ps2, prf_rdy2, cdb_valid, cdb_preg);
         rob_pd_new    = head_uop.pd_new;
         rob_pd_old    = head_uop.pd_old;
         query_ps1     = head_uop.ps1;
         query_ps2     = head_uop.ps2;
      end
   end

   always_comb begin
      fifo_cnt = '0;
      for (int i = 0; i < N_FU; i++)
         fifo_cnt[i*CNT_W +: CNT_W] = cnt[i];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr <= '0;
         for (int i = 0; i < N_FU; i++) begin
            head[i] <= '0;
            cnt[i]  <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < N_FU; i++)
            cnt[i] <= keep[i];
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            cnt[i] <= cnt[i] + CNT_W'(push_fu[i]) - CNT_W'(pop_fu[i]);
            if (pop_fu[i]) head[i] <= head[i] + PTR_W'(1);
         end
         if (gnt_any) rr <= (gnt == SEL_W'(N_FU-1)) ? '0 : gnt + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_FU; i++)
         if (push_fu[i]) mem[i][head[i] + cnt[i][PTR_W-1:0]] <= in_uop;
   end

endmodule

// File: tb/tb_dispatch_multi_fu.sv
// tb/tb_dispatch_multi_fu.sv - scoreboard bench for dispatch_multi_fu
module tb_dispatch_multi_fu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [2:0]  in_fu_sel;
   logic [6:0]  in_pd_new, in_pd_old, in_ps1, in_ps2;
   logic [4:0]  in_rob_tag;
   logic [63:0] in_payload;
   logic        nr_valid;
   logic [6:0]  nr_reg, query_ps1, query_ps2;
   logic        prf_rdy1, prf_rdy2;
   logic [2:0]  cdb_valid;
   logic [20:0] cdb_preg;
   logic [2:0]  rs_ready, rs_valid;
   logic [6:0]  out_pd_new, out_ps1, out_ps2;
   logic [4:0]  out_rob_tag;
   logic [63:0] out_payload;
   logic        out_rdy1, out_rdy2;
   logic        rob_full;
   logic [4:0]  rob_head;
   logic        rob_we;
   logic [6:0]  rob_pd_new, rob_pd_old;
   logic        flush;
   logic [4:0]  flush_tag;
   logic [5:0]  fifo_cnt;

   typedef struct {
      logic [2:0]  rs;
      logic [6:0]  pdn, pdo, ps1, ps2;
      logic [4:0]  tag;
      logic [63:0] pl;
      logic        r1, r2;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   dispatch_multi_fu dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_fu_sel(in_fu_sel),
      .in_pd_new(in_pd_new), .in_pd_old(in_pd_old), .in_ps1(in_ps1), .in_ps2(in_ps2),
      .in_rob_tag(in_rob_tag), .in_payload(in_payload), .nr_valid(nr_valid), .nr_reg(nr_reg),
      .query_ps1(query_ps1), .query_ps2(query_ps2), .prf_rdy1(prf_rdy1), .prf_rdy2(prf_rdy2),
      .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .rs_ready(rs_ready), .rs_valid(rs_valid),
      .out_pd_new(out_pd_new), .out_ps1(out_ps1), .out_ps2(out_ps2), .out_rob_tag(out_rob_tag),
      .out_payload(out_payload), .out_rdy1(out_rdy1), .out_rdy2(out_rdy2), .rob_full(rob_full),
      .rob_head(rob_head), .rob_we(rob_we), .rob_pd_new(rob_pd_new), .rob_pd_old(rob_pd_old),
      .flush(flush), .flush_tag(flush_tag), .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pl_of(input logic [4:0] tag);
      return {32'hC0DE_0000, 27'd0, tag};
   endfunction

   function automatic logic [6:0] pdo_of(input logic [4:0] tag);
      return {2'b10, tag};
   endfunction

   task automatic expect_grant(input logic [2:0] rs, input logic [4:0] tag, input logic [6:0] pdn,
                               input logic [6:0] ps1, input logic [6:0] ps2, input logic r1, input logic r2);
      exp_t e;
      e.rs = rs; e.tag = tag; e.pdn = pdn; e.pdo = pdo_of(tag);
      e.ps1 = ps1; e.ps2 = ps2; e.pl = pl_of(tag); e.r1 = r1; e.r2 = r2;
      sb.push_back(e);
   endtask

   // called at posedge+1; presents one uop for one cycle
   task automatic send(input logic [2:0] sel, input logic [4:0] tag, input logic [6:0] pdn,
                       input logic [6:0] ps1, input logic [6:0] ps2, input logic exp_rdy, input logic exp_nr);
      in_valid = 1'b1; in_fu_sel = sel; in_rob_tag = tag; in_pd_new = pdn;
      in_pd_old = pdo_of(tag); in_ps1 = ps1; in_ps2 = ps2; in_payload = pl_of(tag);
      @(negedge clk);
      check("in_ready", in_ready, exp_rdy);
      check("nr_valid", nr_valid, exp_nr);
      if (exp_nr) check("nr_reg", nr_reg, pdn);
      @(posedge clk); #1;
      in_valid = 1'b0; in_fu_sel = '0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_queue_empty", sb.size(), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rs_valid != '0 || rob_we) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_grant: rs_valid=%b rob_we=%b tag=%0d expected no grant",
                        rs_valid, rob_we, out_rob_tag);
            end else begin
               e = sb.pop_front();
               check("rs_valid", rs_valid, e.rs);
               check("rob_we", rob_we, 1);
               check("out_rob_tag", out_rob_tag, e.tag);
               check("out_pd_new", out_pd_new, e.pdn);
               check("rob_pd_new", rob_pd_new, e.pdn);
               check("rob_pd_old", rob_pd_old, e.pdo);
               check("out_ps1", out_ps1, e.ps1);
               check("out_ps2", out_ps2, e.ps2);
               check("query_ps1", query_ps1, e.ps1);
               check("query_ps2", query_ps2, e.ps2);
               check("out_payload", out_payload, e.pl);
               check("out_rdy1", out_rdy1, e.r1);
               check("out_rdy2", out_rdy2, e.r2);
            end
         end else begin
            check("idle_outputs", {out_pd_new, out_ps1, out_ps2, out_rob_tag, rob_pd_new, rob_pd_old,
                                   query_ps1, query_ps2, out_rdy1, out_rdy2}, 0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      reset = 1'b0; in_valid = 1'b0; in_fu_sel = '0; in_pd_new = '0; in_pd_old = '0;
      in_ps1 = '0; in_ps2 = '0; in_rob_tag = '0; in_payload = '0; prf_rdy1 = 1'b1; prf_rdy2 = 1'b1;
      cdb_valid = '0; cdb_preg = '0; rs_ready = '0; rob_full = 1'b0; rob_head = '0;
      flush = 1'b0; flush_tag = '0;
      cycles(2);
      check("reset_fifo_cnt", fifo_cnt, 0);
      check("reset_rs_valid", rs_valid, 0);
      check("reset_rob_we", rob_we, 0);
      reset = 1'b1;
      cycles(1);
      check("idle_in_ready", in_ready, 1);

      // round-robin across all three FUs starting from rr=0
      send(3'b001, 5'd1, 7'd33, 7'd3, 7'd4, 1, 1);
      send(3'b010, 5'd2, 7'd34, 7'd5, 7'd6, 1, 1);
      send(3'b100, 5'd3, 7'd35, 7'd7, 7'd8, 1, 1);
      send(3'b001, 5'd4, 7'd36, 7'd9, 7'd10, 1, 1);
      check("rr_fill_cnt", fifo_cnt, 6'b01_01_10);
      expect_grant(3'b001, 5'd1, 7'd33, 7'd3, 7'd4, 1, 1);
      expect_grant(3'b010, 5'd2, 7'd34, 7'd5, 7'd6, 1, 1);
      expect_grant(3'b100, 5'd3, 7'd35, 7'd7, 7'd8, 1, 1);
      expect_grant(3'b001, 5'd4, 7'd36, 7'd9, 7'd10, 1, 1);
      rs_ready = 3'b111;
      drain(10);
      rs_ready = '0;
      check("rr_empty_cnt", fifo_cnt, 0);

      // backpressure, then full FIFO granted while rename retries
      send(3'b001, 5'd5, 7'd37, 7'd1, 7'd2, 1, 1);
      send(3'b001, 5'd6, 7'd38, 7'd1, 7'd2, 1, 1);
      send(3'b001, 5'd7, 7'd39, 7'd1, 7'd2, 0, 0);
      check("bp_full_cnt", fifo_cnt, 6'b00_00_10);
      expect_grant(3'b001, 5'd5, 7'd37, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b001, 5'd6, 7'd38, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b001, 5'd7, 7'd39, 7'd1, 7'd2, 1, 1);
      rs_ready = 3'b001;
      send(3'b001, 5'd7, 7'd39, 7'd1, 7'd2, 0, 0);
      send(3'b001, 5'd7, 7'd39, 7'd1, 7'd2, 1, 1);
      check("bp_same_cycle_cnt", fifo_cnt, 6'b00_00_01);
      drain(10);
      rs_ready = '0;
      check("bp_empty_cnt", fifo_cnt, 0);

      send(3'b000, 5'd8, 7'd40, 7'd0, 7'd0, 1, 0);
      check("drop_cnt", fifo_cnt, 0);

      // source readiness: CDB bypass, invalid CDB port, direct PRF, pd_new==0
      prf_rdy1 = 1'b0; prf_rdy2 = 1'b0;
      cdb_valid = 3'b100; cdb_preg = {7'd12, 7'd0, 7'd0};
      send(3'b010, 5'd8, 7'd40, 7'd12, 7'd0, 1, 1);
      expect_grant(3'b010, 5'd8, 7'd40, 7'd12, 7'd0, 1, 1);
      rs_ready = 3'b010;
      drain(10);
      rs_ready = '0;
      cdb_valid = 3'b010; cdb_preg = {7'd12, 7'd13, 7'd0};
      send(3'b100, 5'd9, 7'd41, 7'd12, 7'd13, 1, 1);
      expect_grant(3'b100, 5'd9, 7'd41, 7'd12, 7'd13, 0, 1);
      rs_ready = 3'b100;
      drain(10);
      rs_ready = '0;
      cdb_valid = '0; prf_rdy1 = 1'b1;
      send(3'b001, 5'd10, 7'd0, 7'd5, 7'd6, 1, 0);
      expect_grant(3'b001, 5'd10, 7'd0, 7'd5, 7'd6, 1, 0);
      rs_ready = 3'b001;
      drain(10);
      rs_ready = '0;
      prf_rdy2 = 1'b1;

      // flush with ROB wrap: head=30, tag 3 is younger than branch tag 1
      rob_head = 5'd30;
      send(3'b010, 5'd31, 7'd50, 7'd1, 7'd2, 1, 1);
      send(3'b010, 5'd1, 7'd51, 7'd1, 7'd2, 1, 1);
      send(3'b001, 5'd3, 7'd52, 7'd1, 7'd2, 1, 1);
      check("flush_pre_cnt", fifo_cnt, 6'b00_10_01);
      flush = 1'b1; flush_tag = 5'd1; rs_ready = 3'b111;
      send(3'b100, 5'd4, 7'd53, 7'd1, 7'd2, 0, 0);
      flush = 1'b0; rs_ready = '0;
      check("flush_post_cnt", fifo_cnt, 6'b00_10_00);
      expect_grant(3'b010, 5'd31, 7'd50, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b010, 5'd1, 7'd51, 7'd1, 7'd2, 1, 1);
      rs_ready = 3'b111;
      drain(10);
      rs_ready = '0;
      check("flush_empty_cnt", fifo_cnt, 0);

      send(3'b100, 5'd30, 7'd54, 7'd1, 7'd2, 1, 1);
      send(3'b100, 5'd31, 7'd55, 7'd1, 7'd2, 1, 1);
      flush = 1'b1; flush_tag = 5'd30;
      cycles(1);
      flush = 1'b0;
      check("flush_keep_cnt", fifo_cnt, 6'b01_00_00);
      expect_grant(3'b100, 5'd30, 7'd54, 7'd1, 7'd2, 1, 1);
      rs_ready = 3'b111;
      drain(10);
      rs_ready = '0;

      // ROB full blocks every grant while accepts continue
      rob_full = 1'b1; rs_ready = 3'b111;
      send(3'b001, 5'd11, 7'd60, 7'd1, 7'd2, 1, 1);
      send(3'b010, 5'd12, 7'd61, 7'd1, 7'd2, 1, 1);
      send(3'b100, 5'd13, 7'd62, 7'd1, 7'd2, 1, 1);
      send(3'b001, 5'd14, 7'd63, 7'd1, 7'd2, 1, 1);
      send(3'b001, 5'd15, 7'd64, 7'd1, 7'd2, 0, 0);
      check("robfull_cnt", fifo_cnt, 6'b01_01_10);
      expect_grant(3'b001, 5'd11, 7'd60, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b010, 5'd12, 7'd61, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b100, 5'd13, 7'd62, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b001, 5'd14, 7'd63, 7'd1, 7'd2, 1, 1);
      rob_full = 1'b0;
      drain(10);
      rs_ready = '0;

      // async reset mid-operation clears queues and the rr pointer
      send(3'b001, 5'd16, 7'd65, 7'd1, 7'd2, 1, 1);
      send(3'b010, 5'd17, 7'd66, 7'd1, 7'd2, 1, 1);
      check("pre_reset_cnt", fifo_cnt, 6'b00_01_01);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_cnt", fifo_cnt, 0);
      rs_ready = 3'b111;
      cycles(1);
      check("in_reset_rs_valid", rs_valid, 0);
      check("in_reset_rob_we", rob_we, 0);
      reset = 1'b1; rs_ready = '0;
      send(3'b010, 5'd18, 7'd67, 7'd1, 7'd2, 1, 1);
      send(3'b001, 5'd19, 7'd68, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b001, 5'd19, 7'd68, 7'd1, 7'd2, 1, 1);
      expect_grant(3'b010, 5'd18, 7'd67, 7'd1, 7'd2, 1, 1);
      rs_ready = 3'b011;
      drain(10);
      rs_ready = '0;

      cycles(2);
      check("final_cnt", fifo_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
